// File: rtl/data_memory_sized.sv
// Byte-addressable data memory: byte/half/word loads and stores on a valid/ready port,
// registered one-cycle response, misalignment faults and an optional post-reset zero sweep.
`timescale 1ns/1ps
module data_memory_sized #(
    parameter int DEPTH          = 256,
    parameter int IDX_W          = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic        resp_valid,
    output logic [31:0] readData,
    output logic        fault
);

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             clearing;

    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic             misaligned;
    logic             accept;
    logic             clear_we;
    logic             store_en;
    logic             rd_en;
    logic [3:0]       lane_mask;
    logic [3:0]       lane_we;
    logic [31:0]      store_data;
    logic [31:0]      wr_data;
    logic [IDX_W-1:0] wr_addr;
    logic [31:0]      raw_word;

    logic             resp_valid_q;
    logic             fault_q;
    logic             load_q;
    logic [1:0]       size_q;
    logic [1:0]       lane_q;
    logic             unsigned_q;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      ext_data;
    logic             unused_addr;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_INIT) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        clearing  = (state_q == ST_INIT);
    end

    assign word_idx    = address[IDX_W+1:2];
    assign lane        = address[1:0];
    assign unused_addr = ^address[31:IDX_W+2];

    always_comb begin
        misaligned = 1'b0;
        lane_mask  = 4'b1111;
        store_data = writeData;
        case (req_size)
            2'b00: begin
                lane_mask  = 4'b0001 << lane;
                store_data = {4{writeData[7:0]}};
            end
            2'b01: begin
                misaligned = lane[0];
                lane_mask  = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{writeData[15:0]}};
            end
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Reset has priority: nothing is accepted or cleared on a reset edge.
    assign accept   = req_valid && req_ready && reset_n;
    assign clear_we = clearing && reset_n;
    assign store_en = accept && req_write && !misaligned;
    assign rd_en    = accept && !req_write && !misaligned;
    assign wr_addr  = clear_we ? clr_idx_q : word_idx;
    assign wr_data  = clear_we ? 32'd0 : store_data;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_byte_q;

            assign lane_we[gi] = clear_we || (store_en && lane_mask[gi]);

            always_ff @(posedge clock) begin
                if (lane_we[gi]) begin
                    mem[wr_addr] <= wr_data[gi*8 +: 8];
                end
                if (rd_en) begin
                    rd_byte_q <= mem[word_idx];
                end
            end

            assign raw_word[gi*8 +: 8] = rd_byte_q;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            load_q       <= 1'b0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            unsigned_q   <= 1'b0;
        end else begin
            resp_valid_q <= accept;
            if (accept) begin
                fault_q    <= misaligned;
                load_q     <= !req_write && !misaligned;
                size_q     <= req_size;
                lane_q     <= lane;
                unsigned_q <= req_unsigned;
            end
        end
    end

    // Extension works on the registered word, so readData holds between responses.
    always_comb begin
        half_sel = lane_q[1] ? raw_word[31:16] : raw_word[15:0];
        case (lane_q)
            2'd0:    byte_sel = raw_word[7:0];
            2'd1:    byte_sel = raw_word[15:8];
            2'd2:    byte_sel = raw_word[23:16];
            default: byte_sel = raw_word[31:24];
        endcase
        case (size_q)
            2'b00:   ext_data = {{24{!unsigned_q && byte_sel[7]}}, byte_sel};
            2'b01:   ext_data = {{16{!unsigned_q && half_sel[15]}}, half_sel};
            default: ext_data = raw_word;
        endcase
    end

    assign resp_valid = resp_valid_q;
    assign fault      = fault_q;
    assign readData   = load_q ? ext_data : 32'd0;

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized (DEPTH=16): a byte-level reference model checked
// every cycle, plus hand-computed expectations on the key responses.
`timescale 1ns/1ps
module tb_data_memory_sized;

    localparam int DEPTH = 16;
    localparam int BYTES = 4 * DEPTH;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        resp_valid;
    logic [31:0] readData;
    logic        fault;

    int n_cmp = 0;
    int n_err = 0;

    data_memory_sized #(.DEPTH(DEPTH), .IDX_W(4), .CLEAR_ON_RESET(1'b1)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .address(address), .writeData(writeData),
        .resp_valid(resp_valid), .readData(readData), .fault(fault)
    );

    always #5 clock = ~clock;

    // Reference model: a flat byte array and the response the DUT must present after each edge.
    logic [7:0]  m_mem [BYTES];
    logic        m_started = 1'b0;
    int          m_init_left = 0;
    logic        m_ready = 1'b0;
    logic        m_rv = 1'b0;
    logic [31:0] m_rd = 32'd0;
    logic        m_ft = 1'b0;

    always @(posedge clock) begin
        int a;
        int nb;
        logic [31:0] v;
        if (!reset_n) begin
            m_started   = 1'b1;
            m_init_left = DEPTH;
            m_rv = 1'b0; m_rd = 32'd0; m_ft = 1'b0;
            for (int i = 0; i < BYTES; i++) m_mem[i] = 8'h00;
        end else if (m_started) begin
            if (m_init_left > 0) begin
                m_init_left = m_init_left - 1;
                m_rv = 1'b0;
            end else if (req_valid) begin
                m_rv = 1'b1;
                a  = int'(address[5:0]);
                nb = 1 << req_size;
                if (req_size == 2'd3 || (a % nb) != 0) begin
                    m_ft = 1'b1; m_rd = 32'd0;
                end else if (req_write) begin
                    m_ft = 1'b0; m_rd = 32'd0;
                    for (int k = 0; k < nb; k++) m_mem[a + k] = writeData[8*k +: 8];
                end else begin
                    m_ft = 1'b0;
                    v = 32'd0;
                    for (int k = 0; k < nb; k++) v[8*k +: 8] = m_mem[a + k];
                    if (nb < 4 && !req_unsigned && v[8*nb-1])
                        for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
                    m_rd = v;
                end
            end else begin
                m_rv = 1'b0;
            end
        end
        m_ready = m_started && (m_init_left == 0);
    end

    always @(negedge clock) begin
        if (m_started) begin
            n_cmp++;
            if (req_ready !== m_ready) begin
                n_err++;
                $display("FAIL model req_ready t=%0t: got %b want %b", $time, req_ready, m_ready);
            end
            n_cmp++;
            if (resp_valid !== m_rv) begin
                n_err++;
                $display("FAIL model resp_valid t=%0t: got %b want %b", $time, resp_valid, m_rv);
            end
            n_cmp++;
            if (readData !== m_rd || fault !== m_ft) begin
                n_err++;
                $display("FAIL model data t=%0t: got %h/%b want %h/%b", $time, readData, fault, m_rd, m_ft);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic check_resp(input string name, input logic [31:0] exp_data, input logic exp_fault);
        chk({name, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({name, " readData"}, readData, exp_data);
        chk({name, " fault"}, {31'd0, fault}, {31'd0, exp_fault});
        $display("resp %s: readData=%h fault=%b", name, readData, fault);
    endtask

    // Drive one request for one cycle; returns #1 after the accepting edge.
    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clock);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        address = addr; writeData = wd;
        @(posedge clock);
        #1;
    endtask

    task automatic go_idle();
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        bit done = 0;
        while (!done && n < 100) begin
            @(posedge clock);
            #1;
            n++;
            if (req_ready) done = 1;
        end
        chk(name, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
        req_unsigned = 1'b0; address = 32'h0; writeData = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset readData", readData, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        wait_ready("init sweep cycles");
        @(posedge clock);
        #1;
        check_resp("lw @0 after init", 32'h0000_0000, 1'b0);

        issue(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF);
        check_resp("sw @8 ack", 32'h0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        check_resp("lw @8", 32'hDEAD_BEEF, 1'b0);

        issue(1'b1, 2'b10, 1'b0, 32'h4, 32'h0);
        issue(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_0180);
        issue(1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
        check_resp("lb @5", 32'hFFFF_FF80, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 32'h5, 32'h0);
        check_resp("lbu @5", 32'h0000_0080, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        check_resp("lw @4", 32'h0000_8000, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h4, 32'h0);
        check_resp("lh @4", 32'hFFFF_8000, 1'b0);
        go_idle();

        issue(1'b1, 2'b10, 1'b0, 32'hC, 32'h1122_3344);
        issue(1'b1, 2'b01, 1'b0, 32'hD, 32'h0000_AAAA);
        check_resp("sh @D misaligned", 32'h0, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h2, 32'h0);
        check_resp("lw @2 misaligned", 32'h0, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'hC, 32'h0);
        check_resp("lw @C intact", 32'h1122_3344, 1'b0);
        issue(1'b0, 2'b01, 1'b1, 32'hE, 32'h0);
        check_resp("lhu @E", 32'h0000_1122, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'hC, 32'h0);
        check_resp("lb @C", 32'h0000_0044, 1'b0);
        issue(1'b0, 2'b11, 1'b0, 32'hC, 32'h0);
        check_resp("reserved size", 32'h0, 1'b1);
        go_idle();
        @(posedge clock);
        #1;
        chk("idle resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("idle readData hold", readData, 32'h0);

        issue(1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFE_F00D);
        issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        check_resp("lw @0 wrapped", 32'hCAFE_F00D, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        check_resp("b2b lw @8", 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 32'h3, 32'h0);
        check_resp("b2b lbu @3", 32'h0000_00CA, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h40, 32'h0);
        check_resp("b2b lh @40", 32'hFFFF_F00D, 1'b0);

        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        check_resp("lw before reset", 32'hDEAD_BEEF, 1'b0);
        @(negedge clock);
        reset_n = 1'b0; req_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("mid reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid reset req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        wait_ready("re-init sweep cycles");
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        check_resp("lw @8 after re-init", 32'h0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        check_resp("lw @0 after re-init", 32'h0, 1'b0);
        go_idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
